// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns PCF, fetches over a req/ack port, feeds the IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds perf_fetched / perf_redirects counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] cmd,
  output logic [31:0] PCPlusFourD,
  output logic        validD,
  output logic        FetchBusyF
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_fetched,
  output logic [CNT_W-1:0] perf_redirects
`endif
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pcf;
  logic [31:0] w_pcf_nxt;
  logic [31:0] r_skid;
  logic [31:0] w_skid_nxt;
  logic [31:0] r_cmd;
  logic [31:0] w_cmd_nxt;
  logic [31:0] r_pc4;
  logic [31:0] w_pc4_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        w_deliver;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pcf_inc;

  // A stalled ID stage cannot resolve a redirect; jumps take priority over branches.
  assign w_redirect = !StallD && (JumpD || PCSrcD);
  assign w_target   = (JumpD ? PCJumpD : PCBranchD) & ~32'h3;
  assign w_pcf_inc  = r_pcf + 32'd4;

  assign imem_req    = !reset && (r_state == S_FETCH || r_state == S_WAIT);
  assign imem_addr   = r_pcf;
  assign FetchBusyF  = (r_state == S_WAIT) && !imem_ack;
  assign cmd         = r_cmd;
  assign PCPlusFourD = r_pc4;
  assign validD      = r_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_pcf_nxt   = r_pcf;
    w_skid_nxt  = r_skid;
    w_cmd_nxt   = r_cmd;
    w_pc4_nxt   = r_pc4;
    w_valid_nxt = r_valid;
    w_deliver   = 1'b0;

    if (w_redirect) begin
      w_pcf_nxt   = w_target;
      w_cmd_nxt   = 32'h0;
      w_valid_nxt = 1'b0;
      // An un-acked request is still in flight and its data must be swallowed.
      case (r_state)
        S_HOLD:  w_state_nxt = S_FETCH;
        default: w_state_nxt = imem_ack ? S_FETCH : S_DISCARD;
      endcase
    end else begin
      case (r_state)
        S_FETCH, S_WAIT: begin
          if (imem_ack && !StallD) begin
            w_deliver   = 1'b1;
            w_cmd_nxt   = imem_rdata;
            w_pc4_nxt   = w_pcf_inc;
            w_valid_nxt = 1'b1;
            w_pcf_nxt   = w_pcf_inc;
            w_state_nxt = S_FETCH;
          end else if (imem_ack) begin
            w_skid_nxt  = imem_rdata;
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_WAIT;
            if (!StallD) begin
              w_cmd_nxt   = 32'h0;
              w_valid_nxt = 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (!StallD) begin
            w_deliver   = 1'b1;
            w_cmd_nxt   = r_skid;
            w_pc4_nxt   = w_pcf_inc;
            w_valid_nxt = 1'b1;
            w_pcf_nxt   = w_pcf_inc;
            w_state_nxt = S_FETCH;
          end
        end
        default: begin
          if (imem_ack) begin
            w_state_nxt = S_FETCH;
          end
          if (!StallD) begin
            w_cmd_nxt   = 32'h0;
            w_valid_nxt = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pcf   <= RESET_PC;
      r_skid  <= 32'h0;
      r_cmd   <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcf   <= w_pcf_nxt;
      r_skid  <= w_skid_nxt;
      r_cmd   <= w_cmd_nxt;
      r_pc4   <= w_pc4_nxt;
      r_valid <= w_valid_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_fetched;
  logic [CNT_W-1:0] r_perf_redirects;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched   <= '0;
      r_perf_redirects <= '0;
    end else begin
      if (w_deliver) begin
        r_perf_fetched <= r_perf_fetched + 1'b1;
      end
      if (w_redirect) begin
        r_perf_redirects <= r_perf_redirects + 1'b1;
      end
    end
  end

  assign perf_fetched   = r_perf_fetched;
  assign perf_redirects = r_perf_redirects;
`endif

endmodule
